dcm_lock_ctrl: RTL

DCM_LOCK_CTRL -- requirements
Module: dcm_lock_ctrl

---
 rtl/dcm_lock_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dcm_lock_ctrl.sv
// DCM bring-up sequencer: pulses DCM reset, waits for a stable lock, then releases system reset.
// Optional macro DCM_STATUS_MON_EN treats a stopped CLKIN (status bit 1) as loss of lock.
module dcm_lock_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       dcm_locked_i,
  input  logic [7:0] dcm_status_i,
  input  logic       restart_i,
  output logic       dcm_rst_o,
  output logic       sys_rst_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [1:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    S_RESET_DCM,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] ST_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [1:0]  MAX_R    = 2'(MAX_RETRIES);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_retry;
  logic        r_lock_s1;
  logic        r_lock_s2;
  logic        r_dcm_rst;
  logic        r_sys_rst;
  logic        r_locked;
  logic        r_fail;

  state_t      w_nxt;
  logic [15:0] w_cnt_nxt;
  logic [1:0]  w_retry_nxt;
  logic        w_retry_req;
  logic        w_stat_bad;
  logic        w_lost;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= dcm_locked_i;
      r_lock_s2 <= r_lock_s1;
    end
  end

`ifdef DCM_STATUS_MON_EN
  logic r_stat_s1;
  logic r_stat_s2;
  logic w_unused_status;

  assign w_unused_status = ^{dcm_status_i[7:2], dcm_status_i[0]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stat_s1 <= 1'b0;
      r_stat_s2 <= 1'b0;
    end else begin
      r_stat_s1 <= dcm_status_i[1];
      r_stat_s2 <= r_stat_s1;
    end
  end

  assign w_stat_bad = r_stat_s2;
`else
  logic w_unused_status;

  assign w_unused_status = ^dcm_status_i;
  assign w_stat_bad      = 1'b0;
`endif

  // Only STABLE and RUN consult w_lost, so status only matters there.
  assign w_lost = !r_lock_s2 || w_stat_bad;

  always_comb begin
    w_nxt       = r_state;
    w_retry_nxt = r_retry;
    w_retry_req = 1'b0;
    w_cnt_nxt   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    unique case (r_state)
      S_RESET_DCM: begin
        if (r_cnt == RST_LAST) begin
          w_nxt     = S_WAIT_LOCK;
          w_cnt_nxt = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (r_lock_s2) begin
          w_nxt     = S_STABLE;
          w_cnt_nxt = '0;
        end else if (r_cnt == TO_LAST) begin
          w_retry_req = 1'b1;
        end
      end
      S_STABLE: begin
        if (w_lost) begin
          w_retry_req = 1'b1;
        end else if (r_cnt == ST_LAST) begin
          w_nxt       = S_RUN;
          w_retry_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_lost) w_retry_req = 1'b1;
      end
      S_FAIL: begin
        if (restart_i) begin
          w_nxt       = S_RESET_DCM;
          w_retry_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_nxt     = S_RESET_DCM;
        w_cnt_nxt = '0;
      end
    endcase
    if (w_retry_req) begin
      w_cnt_nxt = '0;
      if (r_retry == MAX_R) begin
        w_nxt = S_FAIL;
      end else begin
        w_nxt       = S_RESET_DCM;
        w_retry_nxt = r_retry + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_RESET_DCM;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_dcm_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt_nxt;
      r_retry   <= w_retry_nxt;
      r_dcm_rst <= (w_nxt == S_RESET_DCM);
      r_sys_rst <= (w_nxt != S_RUN);
      r_locked  <= (w_nxt == S_RUN);
      r_fail    <= (w_nxt == S_FAIL);
    end
  end

  assign dcm_rst_o   = r_dcm_rst;
  assign sys_rst_o   = r_sys_rst;
  assign locked_o    = r_locked;
  assign fail_o      = r_fail;
  assign retry_cnt_o = r_retry;

endmodule
